// File: rtl/player_mover.sv
// Steps the player one pixel per accepted button request and cycles its colour; registered outputs,
// and requests arriving while busy (SETTLE) are ignored except colour rises, which are latched for IDLE.
module player_mover #(
  parameter int N_OBJ      = 8,
  parameter int PWIDTH     = 12,
  parameter int PHEIGHT    = 12,
  parameter int H_RES      = 640,
  parameter int V_RES      = 480,
  parameter int H_START    = 314,
  parameter int V_START    = 234,
  parameter int NUM_COLORS = 4,
  parameter int SETTLE_CYC = 1
) (
  input  logic             btnClk,
  input  logic             rst,
  input  logic [3:0]       btns,
  input  logic             color_btn,
  input  logic [N_OBJ-1:0] up_block,
  input  logic [N_OBJ-1:0] down_block,
  input  logic [N_OBJ-1:0] left_block,
  input  logic [N_OBJ-1:0] right_block,
  output logic [9:0]       player_hPos,
  output logic [9:0]       player_vPos,
  output logic [3:0]       player_color,
  output logic             busy,
  output logic             bump,
  output logic [15:0]      step_count
);

  localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

  typedef enum logic {IDLE, SETTLE} state_t;

  state_t          state, stateNxt;
  logic [9:0]      hNxt, vNxt;
  logic [3:0]      colorNxt;
  logic [15:0]     stepNxt;
  logic [CW-1:0]   cnt, cntNxt;
  logic            colorPending, pendNxt, colorBtnQ, bumpNxt;
  logic            rise, blkU, blkD, blkL, blkR;
  logic            reqU, reqD, reqL, reqR, reqAny, canMove;

  assign rise = color_btn & ~colorBtnQ;
  assign blkU = |up_block;
  assign blkD = |down_block;
  assign blkL = |left_block;
  assign blkR = |right_block;

  assign reqU   = (btns == 4'b1000);
  assign reqD   = (btns == 4'b0100);
  assign reqR   = (btns == 4'b0010);
  assign reqL   = (btns == 4'b0001);
  assign reqAny = reqU | reqD | reqR | reqL;

  // Limits are compared one bit wider so the right/bottom sums cannot wrap.
  always_comb begin
    canMove = 1'b0;
    if (reqU) canMove = ~blkU && (player_vPos != 10'd0);
    if (reqD) canMove = ~blkD && (({1'b0, player_vPos} + 11'(PHEIGHT)) < 11'(V_RES));
    if (reqL) canMove = ~blkL && (player_hPos != 10'd0);
    if (reqR) canMove = ~blkR && (({1'b0, player_hPos} + 11'(PWIDTH)) < 11'(H_RES));
  end

  always_comb begin
    stateNxt = state;
    hNxt     = player_hPos;
    vNxt     = player_vPos;
    colorNxt = player_color;
    stepNxt  = step_count;
    cntNxt   = cnt;
    pendNxt  = colorPending | rise;
    bumpNxt  = 1'b0;
    case (state)
      IDLE: begin
        if (colorPending | rise) begin
          colorNxt = (player_color == 4'(NUM_COLORS - 1)) ? 4'd0 : player_color + 4'd1;
          pendNxt  = 1'b0;
          cntNxt   = CW'(SETTLE_CYC - 1);
          stateNxt = SETTLE;
        end else if (reqAny) begin
          if (canMove) begin
            if (reqU) vNxt = player_vPos - 10'd1;
            if (reqD) vNxt = player_vPos + 10'd1;
            if (reqL) hNxt = player_hPos - 10'd1;
            if (reqR) hNxt = player_hPos + 10'd1;
            stepNxt  = (step_count == 16'hFFFF) ? step_count : step_count + 16'd1;
            cntNxt   = CW'(SETTLE_CYC - 1);
            stateNxt = SETTLE;
          end else begin
            bumpNxt = 1'b1;
          end
        end
      end
      SETTLE: begin
        if (cnt == '0) stateNxt = IDLE;
        else           cntNxt   = cnt - CW'(1);
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge btnClk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      player_hPos  <= 10'(H_START);
      player_vPos  <= 10'(V_START);
      player_color <= 4'd0;
      step_count   <= 16'd0;
      cnt          <= '0;
      colorPending <= 1'b0;
      colorBtnQ    <= 1'b0;
      bump         <= 1'b0;
    end else begin
      state        <= stateNxt;
      player_hPos  <= hNxt;
      player_vPos  <= vNxt;
      player_color <= colorNxt;
      step_count   <= stepNxt;
      cnt          <= cntNxt;
      colorPending <= pendNxt;
      colorBtnQ    <= color_btn;
      bump         <= bumpNxt;
    end
  end

  assign busy = (state == SETTLE);

endmodule

// File: tb/tb_player_mover.sv
// Randomized and directed bench for player_mover; a position/colour reference model feeds a queue
// that a monitor drains one entry per clock edge.
module tb_player_mover;

  localparam int NC     = 4;
  localparam int SETTLE = 1;

  logic        btnClk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  btns = 4'd0;
  logic        color_btn = 1'b0;
  logic [7:0]  up_block = 8'd0, down_block = 8'd0, left_block = 8'd0, right_block = 8'd0;
  logic [9:0]  player_hPos, player_vPos;
  logic [3:0]  player_color;
  logic        busy, bump;
  logic [15:0] step_count;

  player_mover dut (
    .btnClk(btnClk), .rst(rst), .btns(btns), .color_btn(color_btn),
    .up_block(up_block), .down_block(down_block), .left_block(left_block), .right_block(right_block),
    .player_hPos(player_hPos), .player_vPos(player_vPos), .player_color(player_color),
    .busy(busy), .bump(bump), .step_count(step_count)
  );

  always #5 btnClk = ~btnClk;

  typedef struct { int h; int v; int c; int busy; int bump; int steps; } exp_t;
  exp_t expQ[$];

  int nChecks = 0;
  int nFails  = 0;

  // Reference model: position, colour, pending flag, remaining busy edges, step total.
  int  mH, mV, mC, mSettle, mSteps;
  bit  mPend, mPrevCb;

  task automatic chk(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFails++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  always @(posedge btnClk) begin
    #1;
    if (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      chk("hPos",       int'(player_hPos),  e.h);
      chk("vPos",       int'(player_vPos),  e.v);
      chk("color",      int'(player_color), e.c);
      chk("busy",       int'(busy),         e.busy);
      chk("bump",       int'(bump),         e.bump);
      chk("step_count", int'(step_count),   e.steps);
    end
  end

  function automatic exp_t snap(input int bmp);
    exp_t e;
    e.h = mH; e.v = mV; e.c = mC; e.busy = (mSettle > 0) ? 1 : 0; e.bump = bmp; e.steps = mSteps;
    return e;
  endfunction

  task automatic modelReset();
    mH = 314; mV = 234; mC = 0; mSettle = 0; mSteps = 0; mPend = 0; mPrevCb = 0;
  endtask

  task automatic doReset();
    rst = 1'b1; btns = 4'd0; color_btn = 1'b0;
    up_block = 0; down_block = 0; left_block = 0; right_block = 0;
    modelReset();
    expQ.push_back(snap(0));
    @(posedge btnClk); #2;
    rst = 1'b0;
  endtask

  task automatic cycle(input logic [3:0] b, input logic cb,
                       input logic [7:0] u, input logic [7:0] d, input logic [7:0] l, input logic [7:0] r);
    bit rs;
    int bmp;
    bit ok;
    btns = b; color_btn = cb; up_block = u; down_block = d; left_block = l; right_block = r;
    rs = cb && !mPrevCb;
    mPrevCb = cb;
    bmp = 0;
    if (mSettle > 0) begin
      mSettle--;
      mPend = mPend | rs;
    end else if (mPend || rs) begin
      mC = (mC + 1) % NC;
      mPend = 0;
      mSettle = SETTLE;
    end else if (b == 8 || b == 4 || b == 2 || b == 1) begin
      case (b)
        4'd8:    ok = (u == 0) && (mV > 0);
        4'd4:    ok = (d == 0) && (mV + 12 < 480);
        4'd1:    ok = (l == 0) && (mH > 0);
        default: ok = (r == 0) && (mH + 12 < 640);
      endcase
      if (ok) begin
        if (b == 8) mV--;
        if (b == 4) mV++;
        if (b == 1) mH--;
        if (b == 2) mH++;
        if (mSteps < 65535) mSteps++;
        mSettle = SETTLE;
      end else begin
        bmp = 1;
      end
    end
    expQ.push_back(snap(bmp));
    @(posedge btnClk); #2;
  endtask

  task automatic mv(input logic [3:0] b);
    cycle(b, 1'b0, 8'd0, 8'd0, 8'd0, 8'd0);
  endtask

  initial begin
    doReset();
    chk("reset_hPos", int'(player_hPos), 314);
    chk("reset_vPos", int'(player_vPos), 234);

    // held right, no blocks
    mv(4'd2);
    chk("first_move_hPos", int'(player_hPos), 315);
    repeat (3) mv(4'd2);
    chk("two_moves_steps", int'(step_count), 2);

    // blocked right, then left succeeds
    doReset();
    repeat (3) cycle(4'd2, 1'b0, 8'd0, 8'd0, 8'd0, 8'h08);
    chk("blocked_bump", int'(bump), 1);
    cycle(4'd1, 1'b0, 8'd0, 8'd0, 8'd0, 8'h08);
    chk("left_after_block", int'(player_hPos), 313);
    mv(4'd0);

    // screen edges
    doReset();
    while (mH < 628) mv(4'd2);
    repeat (2) mv(4'd0);
    repeat (2) mv(4'd2);
    chk("right_edge_hPos", int'(player_hPos), 628);
    while (mV > 0) mv(4'd8);
    repeat (2) mv(4'd0);
    repeat (2) mv(4'd8);
    chk("top_edge_vPos", int'(player_vPos), 0);
    while (mV < 468) mv(4'd4);
    repeat (2) mv(4'd0);
    repeat (2) mv(4'd4);
    while (mH > 0) mv(4'd1);
    repeat (2) mv(4'd0);
    repeat (2) mv(4'd1);

    // colour rise during SETTLE, then wrap 3 -> 0
    doReset();
    mv(4'd2);
    cycle(4'd0, 1'b1, 0, 0, 0, 0);
    repeat (3) cycle(4'd0, 1'b0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cycle(4'd0, 1'b1, 0, 0, 0, 0);
      repeat (2) cycle(4'd0, 1'b0, 0, 0, 0, 0);
    end
    chk("color_wrap", int'(player_color), 0);

    // colour and down on the same IDLE edge, then reset mid-SETTLE
    cycle(4'd4, 1'b1, 0, 0, 0, 0);
    chk("color_wins_vPos", int'(player_vPos), 234);
    cycle(4'd4, 1'b0, 0, 0, 0, 0);
    cycle(4'd4, 1'b0, 0, 0, 0, 0);
    chk("down_after_color", int'(player_vPos), 235);
    doReset();
    chk("mid_settle_reset_busy", int'(busy), 0);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [3:0] b;
      logic [7:0] u, d, l, r;
      case ($urandom_range(0, 5))
        0: b = 4'd8;
        1: b = 4'd4;
        2: b = 4'd2;
        3: b = 4'd1;
        4: b = 4'd0;
        default: b = 4'($urandom_range(0, 15));
      endcase
      u = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
      d = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
      l = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
      r = ($urandom_range(0, 5) == 0) ? 8'(1 << $urandom_range(0, 7)) : 8'd0;
      cycle(b, 1'($urandom_range(0, 7) == 0), u, d, l, r);
      if ($urandom_range(0, 499) == 0) doReset();
    end

    @(posedge btnClk); #3;
    chk("queue_drained", expQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
